outr_handshake: RTL and testbench

- Output-side counterpart to the input register: the processor writes characters from AC with an OUT strobe, and the block delivers them to an external output device.
- Contains a small FIFO plus a four-phase req/ack transmitter FSM.
- flag is the processor-visible FGO bit: 1 means the block can accept another character.
- Sits between the AC/control unit and the output device, in the same clock domain.

---
 rtl/outr_handshake.sv | 83 ++++++++
 tb/tb_outr_handshake.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/outr_handshake.sv
// Output register: buffers characters written by OUT instructions in a small FIFO
// and delivers them one at a time to the output device over a four-phase req/ack link.
module outr_handshake #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       Data_IN,
  input  logic                   load,
  output logic                   flag,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf,
  input  logic                   ovf_clear,
  output logic [WIDTH-1:0]       Data_OUT,
  output logic                   dev_req,
  input  logic                   dev_ack,
  output logic                   busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, pop, accept, drop, start;

  always_comb begin
    full    = (count == CW'(DEPTH));
    pop     = (state == REQ) && dev_ack;
    // A full FIFO still takes a load when the head leaves in the same cycle.
    accept  = load && (!full || pop);
    drop    = load && !accept;
    state_n = state;
    start   = 1'b0;
    case (state)
      IDLE: if ((count != '0) && !dev_ack) begin
        state_n = REQ;
        start   = 1'b1;
      end
      REQ:     if (dev_ack)  state_n = REL;
      REL:     if (!dev_ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      Data_OUT <= '0;
      dev_req  <= 1'b0;
    end else begin
      state   <= state_n;
      dev_req <= (state_n == REQ);
      if (start)  Data_OUT <= mem[rd_ptr];
      if (accept) wr_ptr   <= wr_ptr + 1'b1;
      if (pop)    rd_ptr   <= rd_ptr + 1'b1;
      count <= count + CW'(accept) - CW'(pop);
      if (drop)           ovf <= 1'b1;
      else if (ovf_clear) ovf <= 1'b0;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= Data_IN;
  end

  assign flag = !full;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_outr_handshake.sv
// Bench for outr_handshake: reference model plus delivery scoreboard, with directed
// scenarios for latency, overflow, full-with-pop, pointer wrap, reset and stuck ack.
module tb_outr_handshake;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             load      = 1'b0;
  logic             ovf_clear = 1'b0;
  logic             dev_ack   = 1'b0;
  logic [WIDTH-1:0] Data_IN   = '0;
  logic             flag, ovf, dev_req, busy;
  logic [2:0]       count;
  logic [WIDTH-1:0] Data_OUT;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_mode = 0; // 0: ack low, 1: ack follows req one cycle later, 2: ack high

  // reference model state
  int               m_cnt, m_st;
  logic             m_ovf;
  logic [WIDTH-1:0] m_dout;
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] sb_q[$];
  logic [WIDTH-1:0] got[$];

  outr_handshake #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .Data_IN(Data_IN), .load(load), .flag(flag),
    .count(count), .ovf(ovf), .ovf_clear(ovf_clear), .Data_OUT(Data_OUT),
    .dev_req(dev_req), .dev_ack(dev_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_st   = 0;
    m_ovf  = 1'b0;
    m_dout = '0;
    mq.delete();
    sb_q.delete();
  endtask

  // Reference model, advanced on each rising edge from the bench-driven inputs.
  initial forever begin
    bit m_pop, m_acc;
    @(posedge clk);
    if (!rst) begin
      m_pop = (m_st == 1) && dev_ack;
      m_acc = load && ((m_cnt != DEPTH) || m_pop);
      if (load && !m_acc) m_ovf = 1'b1;
      else if (ovf_clear) m_ovf = 1'b0;
      case (m_st)
        0: if (m_cnt != 0 && !dev_ack) begin m_dout = mq[0]; m_st = 1; end
        1: if (dev_ack) begin void'(mq.pop_front()); m_st = 2; end
        default: if (!dev_ack) m_st = 0;
      endcase
      if (m_acc) begin
        mq.push_back(Data_IN);
        sb_q.push_back(Data_IN);
      end
      m_cnt = m_cnt + int'(m_acc) - int'(m_pop);
    end
  end

  // Output device
  initial forever begin
    @(negedge clk);
    #1;
    case (ack_mode)
      0:       dev_ack = 1'b0;
      1:       dev_ack = dev_req;
      default: dev_ack = 1'b1;
    endcase
  end

  // Per-cycle comparison against the model; scoreboard pops on each handshake.
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst) begin
      check("count", 32'(count), 32'(m_cnt));
      check("flag", 32'(flag), 32'(m_cnt != DEPTH));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("dev_req", 32'(dev_req), 32'(m_st == 1));
      check("busy", 32'(busy), 32'(m_st != 0));
      check("data_out", 32'(Data_OUT), 32'(m_dout));
      if (dev_req && dev_ack) begin
        check("sb_avail", 32'(sb_q.size() != 0), 32'(1));
        if (sb_q.size() != 0) begin
          check("deliver", 32'(Data_OUT), 32'(sb_q.pop_front()));
          got.push_back(Data_OUT);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((count != 0 || busy || dev_req) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 32'(n < 300), 32'(1));
    @(negedge clk);
  endtask

  task automatic check_got(input string tag, input logic [WIDTH-1:0] exp[$]);
    check({tag, "_n"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check({tag, "_order"}, 32'(got[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [WIDTH-1:0] exp[$];
    int k, n;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_count", 32'(count), 32'(0));
    check("rst_flag", 32'(flag), 32'(1));
    check("rst_ovf", 32'(ovf), 32'(0));
    check("rst_dout", 32'(Data_OUT), 32'(0));
    check("rst_req", 32'(dev_req), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    rst = 1'b0;

    // single write and latency
    got.delete();
    ack_mode = 1;
    @(negedge clk); load = 1'b1; Data_IN = 8'h41;
    @(negedge clk); load = 1'b0;
    check("t1_count", 32'(count), 32'(1));
    check("t1_req_early", 32'(dev_req), 32'(0));
    @(negedge clk);
    check("t1_req", 32'(dev_req), 32'(1));
    check("t1_dout", 32'(Data_OUT), 32'(8'h41));
    wait_idle();
    check("t1_count0", 32'(count), 32'(0));
    check("t1_busy0", 32'(busy), 32'(0));
    check("t1_ovf0", 32'(ovf), 32'(0));
    exp = '{8'h41};
    check_got("t1", exp);

    // burst fill with overflow
    got.delete();
    ack_mode = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); load = 1'b1; Data_IN = 8'(8'h10 + i);
    end
    @(negedge clk); load = 1'b0;
    check("t2_count", 32'(count), 32'(4));
    check("t2_flag", 32'(flag), 32'(0));
    check("t2_ovf", 32'(ovf), 32'(1));
    ack_mode = 1;
    wait_idle();
    exp = '{8'h10, 8'h11, 8'h12, 8'h13};
    check_got("t2", exp);
    check("t2_ovf_sticky", 32'(ovf), 32'(1));
    @(negedge clk); ovf_clear = 1'b1;
    @(negedge clk); ovf_clear = 1'b0;
    check("t2_ovf_clr", 32'(ovf), 32'(0));

    // full plus simultaneous pop
    got.delete();
    ack_mode = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); load = 1'b1; Data_IN = 8'(8'h20 + i);
    end
    @(negedge clk);
    check("t3_full", 32'(count), 32'(4));
    check("t3_req", 32'(dev_req), 32'(1));
    load = 1'b1; Data_IN = 8'hAA; ack_mode = 2;
    @(negedge clk); load = 1'b0; ack_mode = 1;
    check("t3_count", 32'(count), 32'(4));
    check("t3_ovf", 32'(ovf), 32'(0));
    wait_idle();
    exp = '{8'h20, 8'h21, 8'h22, 8'h23, 8'hAA};
    check_got("t3", exp);

    // streaming with pointer wrap
    got.delete();
    ack_mode = 1;
    k = 0; n = 0;
    while (k < 10 && n < 500) begin
      @(negedge clk);
      if (flag) begin load = 1'b1; Data_IN = 8'(k); k++; end
      else load = 1'b0;
      n++;
    end
    @(negedge clk); load = 1'b0;
    check("t4_loaded", 32'(k), 32'(10));
    wait_idle();
    exp.delete();
    for (int i = 0; i < 10; i++) exp.push_back(8'(i));
    check_got("t4", exp);
    check("t4_ovf", 32'(ovf), 32'(0));

    // asynchronous reset mid-transfer
    ack_mode = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); load = 1'b1; Data_IN = 8'(8'h30 + i);
    end
    @(negedge clk); load = 1'b0;
    check("t5_pre_count", 32'(count), 32'(3));
    check("t5_pre_req", 32'(dev_req), 32'(1));
    @(posedge clk); #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("t5_req", 32'(dev_req), 32'(0));
    check("t5_count", 32'(count), 32'(0));
    check("t5_flag", 32'(flag), 32'(1));
    check("t5_dout", 32'(Data_OUT), 32'(0));
    check("t5_busy", 32'(busy), 32'(0));
    @(negedge clk); rst = 1'b0; ack_mode = 1;
    repeat (5) begin
      @(negedge clk);
      check("t5_quiet", 32'(dev_req), 32'(0));
    end

    // ack stuck high while idle
    got.delete();
    ack_mode = 2;
    @(negedge clk);
    @(negedge clk); load = 1'b1; Data_IN = 8'h55;
    @(negedge clk); load = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_req_held", 32'(dev_req), 32'(0));
    check("t6_count", 32'(count), 32'(1));
    check("t6_busy", 32'(busy), 32'(0));
    ack_mode = 1;
    @(negedge clk);
    check("t6_req", 32'(dev_req), 32'(1));
    check("t6_dout", 32'(Data_OUT), 32'(8'h55));
    wait_idle();
    exp = '{8'h55};
    check_got("t6", exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
